// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the pipelined WISC CPU: owns the fetch PC, drives a
// single-outstanding req/valid instruction memory and holds the IF/ID register.
module fetch_stage #(
    parameter int unsigned      WIDTH       = 16,
    parameter int unsigned      PC_STEP     = 2,
    parameter logic [WIDTH-1:0] RESET_PC    = {WIDTH{1'b0}},
    parameter logic [3:0]       HALT_OPCODE = 4'hF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             redirect_i,
    input  logic [WIDTH-1:0] redirect_pc_i,
    output logic             imem_req_o,
    output logic [WIDTH-1:0] imem_addr_o,
    input  logic             imem_valid_i,
    input  logic [WIDTH-1:0] imem_rdata_i,
    output logic             if_id_valid_o,
    output logic [WIDTH-1:0] if_id_instr_o,
    output logic [WIDTH-1:0] if_id_pc_o,
    output logic [WIDTH-1:0] if_id_pcinc_o,
    output logic [WIDTH-1:0] pc_o,
    output logic             halted_o
);

    localparam logic [WIDTH-1:0] STEP_C = WIDTH'(PC_STEP);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_BUF    = 3'd3,
        ST_HALTED = 3'd4
    } state_e;

    state_e           state_r, state_s;
    logic [WIDTH-1:0] pc_r, pc_s, pc_inc_s;
    logic [WIDTH-1:0] buf_r, buf_s;
    logic             deliver_s;
    logic [WIDTH-1:0] deliver_instr_s;
    logic             if_id_valid_r, if_id_valid_s;
    logic [WIDTH-1:0] if_id_instr_r, if_id_instr_s;
    logic [WIDTH-1:0] if_id_pc_r, if_id_pc_s;
    logic [WIDTH-1:0] if_id_pcinc_r, if_id_pcinc_s;
    logic             req_r, halted_r;

    function automatic logic is_halt(input logic [WIDTH-1:0] instr);
        return (instr[WIDTH-1 -: 4] == HALT_OPCODE);
    endfunction

    assign pc_inc_s = pc_r + STEP_C;

    // Next-state, next-PC and skid-buffer logic; the buffered instruction's PC is pc_r.
    always_comb begin
        state_s         = state_r;
        pc_s            = pc_r;
        buf_s           = buf_r;
        deliver_s       = 1'b0;
        deliver_instr_s = imem_rdata_i;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_REQ;
            end
            ST_REQ: begin
                if (imem_valid_i && redirect_i) begin
                    pc_s = redirect_pc_i;
                end else if (imem_valid_i && stall_i) begin
                    buf_s   = imem_rdata_i;
                    state_s = ST_BUF;
                end else if (imem_valid_i) begin
                    deliver_s = 1'b1;
                    if (is_halt(imem_rdata_i)) begin
                        state_s = ST_HALTED;
                    end else begin
                        pc_s = pc_inc_s;
                    end
                end else if (redirect_i) begin
                    pc_s    = redirect_pc_i;
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DRAIN: begin
                // Latest redirect target wins while the abandoned response is still in flight.
                if (redirect_i) begin
                    pc_s = redirect_pc_i;
                end else begin
                    pc_s = pc_r;
                end
                if (imem_valid_i) begin
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_BUF: begin
                if (redirect_i) begin
                    pc_s    = redirect_pc_i;
                    state_s = ST_REQ;
                end else if (!stall_i) begin
                    deliver_s       = 1'b1;
                    deliver_instr_s = buf_r;
                    if (is_halt(buf_r)) begin
                        state_s = ST_HALTED;
                    end else begin
                        pc_s    = pc_inc_s;
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_BUF;
                end
            end
            ST_HALTED: begin
                if (redirect_i) begin
                    pc_s    = redirect_pc_i;
                    state_s = ST_REQ;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // IF/ID update: flush on redirect, load on delivery, hold on stall, else bubble.
    always_comb begin
        if_id_valid_s = if_id_valid_r;
        if_id_instr_s = if_id_instr_r;
        if_id_pc_s    = if_id_pc_r;
        if_id_pcinc_s = if_id_pcinc_r;
        if (redirect_i) begin
            if_id_valid_s = 1'b0;
        end else if (deliver_s) begin
            if_id_valid_s = 1'b1;
            if_id_instr_s = deliver_instr_s;
            if_id_pc_s    = pc_r;
            if_id_pcinc_s = pc_inc_s;
        end else if (stall_i) begin
            if_id_valid_s = if_id_valid_r;
        end else begin
            if_id_valid_s = 1'b0;
        end
    end

    // State, PC, buffer and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            pc_r     <= RESET_PC;
            buf_r    <= {WIDTH{1'b0}};
            req_r    <= 1'b0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            buf_r    <= buf_s;
            req_r    <= (state_s == ST_REQ);
            halted_r <= (state_s == ST_HALTED);
        end
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid_r <= 1'b0;
            if_id_instr_r <= {WIDTH{1'b0}};
            if_id_pc_r    <= {WIDTH{1'b0}};
            if_id_pcinc_r <= {WIDTH{1'b0}};
        end else begin
            if_id_valid_r <= if_id_valid_s;
            if_id_instr_r <= if_id_instr_s;
            if_id_pc_r    <= if_id_pc_s;
            if_id_pcinc_r <= if_id_pcinc_s;
        end
    end

    assign imem_req_o    = req_r;
    assign imem_addr_o   = pc_r;
    assign pc_o          = pc_r;
    assign halted_o      = halted_r;
    assign if_id_valid_o = if_id_valid_r;
    assign if_id_instr_o = if_id_instr_r;
    assign if_id_pc_o    = if_id_pc_r;
    assign if_id_pcinc_o = if_id_pcinc_r;

endmodule
